// File: rtl/data_cache.sv
// Direct-mapped write-through, no-write-allocate data cache for the M stage.
// Define DCACHE_STATS_EN to add hit_count / miss_count outputs.
module data_cache #(
   parameter int DATA_WIDTH = 32,
   parameter int SETS       = 16,
   localparam int INDEX_W   = $clog2(SETS)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   input  logic                  req_write,
   input  logic [DATA_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   input  logic [2:0]            req_funct3,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic                  stall,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [DATA_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   output logic [3:0]            mem_wstrb,
   input  logic                  mem_ack,
   input  logic [DATA_WIDTH-1:0] mem_rdata
`ifdef DCACHE_STATS_EN
   ,
   output logic [31:0]           hit_count,
   output logic [31:0]           miss_count
`endif
);

   localparam int TAG_W = DATA_WIDTH - INDEX_W - 2;

   typedef enum logic [1:0] {
      IDLE,
      RMISS,
      WTHRU
   } state_e;

   state_e                  state_q;
   logic [SETS-1:0]         valid_q;
   logic [TAG_W-1:0]        tag_q  [SETS];
   logic [DATA_WIDTH-1:0]   data_q [SETS];

   logic                    mem_req_q;
   logic                    mem_we_q;
   logic [DATA_WIDTH-1:0]   mem_addr_q;
   logic [DATA_WIDTH-1:0]   mem_wdata_q;
   logic [3:0]              mem_wstrb_q;

   logic [INDEX_W-1:0]      idx;
   logic [TAG_W-1:0]        tag;
   logic [INDEX_W-1:0]      m_idx;
   logic [TAG_W-1:0]        m_tag;
   logic                    hit;
   logic                    m_hit;
   logic                    ld_hit;
   logic                    done;
   logic [DATA_WIDTH-1:0]   aligned;
   logic [DATA_WIDTH-1:0]   st_wdata;
   logic [3:0]              st_strb;
   logic [DATA_WIDTH-1:0]   merged;

   function automatic logic [31:0] load_ext(
      input logic [31:0] w,
      input logic [1:0]  off,
      input logic [2:0]  f3
   );
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      unique case (off)
         2'd0:    b = w[7:0];
         2'd1:    b = w[15:8];
         2'd2:    b = w[23:16];
         default: b = w[31:24];
      endcase
      h = off[1] ? w[31:16] : w[15:0];
      unique case (f3[1:0])
         2'b00:   r = f3[2] ? {24'b0, b} : {{24{b[7]}}, b};
         2'b01:   r = f3[2] ? {16'b0, h} : {{16{h[15]}}, h};
         default: r = w;
      endcase
      return r;
   endfunction

   assign idx     = req_addr[INDEX_W+1:2];
   assign tag     = req_addr[DATA_WIDTH-1:INDEX_W+2];
   assign m_idx   = mem_addr_q[INDEX_W+1:2];
   assign m_tag   = mem_addr_q[DATA_WIDTH-1:INDEX_W+2];
   assign hit     = valid_q[idx] && (tag_q[idx] == tag);
   assign m_hit   = valid_q[m_idx] && (tag_q[m_idx] == m_tag);
   assign aligned = {req_addr[DATA_WIDTH-1:2], 2'b00};

   assign ld_hit = (state_q == IDLE) && req_valid && !req_write && hit;
   assign done   = ld_hit || ((state_q != IDLE) && mem_ack);
   assign stall  = req_valid && !done;

   always_comb begin
      rdata = '0;
      if (ld_hit)
         rdata = load_ext(data_q[idx], req_addr[1:0], req_funct3);
      else if ((state_q == RMISS) && mem_ack)
         rdata = load_ext(mem_rdata, req_addr[1:0], req_funct3);
   end

   // Store data is replicated into every lane so the strobe alone picks bytes
   always_comb begin
      st_strb  = 4'b1111;
      st_wdata = req_wdata;
      unique case (req_funct3[1:0])
         2'b00: begin
            st_strb  = 4'b0001 << req_addr[1:0];
            st_wdata = {4{req_wdata[7:0]}};
         end
         2'b01: begin
            st_strb  = 4'b0011 << {req_addr[1], 1'b0};
            st_wdata = {2{req_wdata[15:0]}};
         end
         default: ;
      endcase
   end

   always_comb begin
      merged = data_q[m_idx];
      for (int i = 0; i < 4; i++)
         if (mem_wstrb_q[i])
            merged[8*i +: 8] = mem_wdata_q[8*i +: 8];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         valid_q     <= '0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_wstrb_q <= '0;
`ifdef DCACHE_STATS_EN
         hit_count   <= '0;
         miss_count  <= '0;
`endif
      end else begin
         unique case (state_q)
            IDLE: begin
               if (req_valid && req_write) begin
                  state_q     <= WTHRU;
                  mem_req_q   <= 1'b1;
                  mem_we_q    <= 1'b1;
                  mem_addr_q  <= aligned;
                  mem_wdata_q <= st_wdata;
                  mem_wstrb_q <= st_strb;
               end else if (req_valid && !hit) begin
                  state_q     <= RMISS;
                  mem_req_q   <= 1'b1;
                  mem_we_q    <= 1'b0;
                  mem_addr_q  <= aligned;
                  mem_wdata_q <= '0;
                  mem_wstrb_q <= '0;
               end
`ifdef DCACHE_STATS_EN
               if (ld_hit)
                  hit_count <= hit_count + 32'd1;
               if (req_valid && !req_write && !hit)
                  miss_count <= miss_count + 32'd1;
`endif
            end
            RMISS, WTHRU: begin
               if (mem_ack) begin
                  if (state_q == RMISS)
                     valid_q[m_idx] <= 1'b1;
                  state_q     <= IDLE;
                  mem_req_q   <= 1'b0;
                  mem_we_q    <= 1'b0;
                  mem_addr_q  <= '0;
                  mem_wdata_q <= '0;
                  mem_wstrb_q <= '0;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Line storage needs no reset; valid_q gates every use of it
   always_ff @(posedge clk) begin
      if ((state_q == RMISS) && mem_ack) begin
         tag_q[m_idx]  <= m_tag;
         data_q[m_idx] <= mem_rdata;
      end else if ((state_q == WTHRU) && mem_ack && m_hit) begin
         data_q[m_idx] <= merged;
      end
   end

   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_wstrb = mem_wstrb_q;

endmodule
